// File: rtl/mips_pkg.sv
// Shared constants and encodings for the MIPS-style pipeline.
// Used by id_ex_stage and hazard_fwd_unit.
package mips_pkg;

  localparam int MIPS_DATA_W = 32;
  localparam int MIPS_REG_AW = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SL1 = 3'b110,
    ALU_SR1 = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EXM = 2'd1,
    FWD_MWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational hazard detect and operand forward select.
// Build option: ID_EX_FWD_EN enables forwarding.
module hazard_fwd_unit
  import mips_pkg::*;
#(
  parameter int REG_AW = MIPS_REG_AW
) (
  input  logic              i_id_valid,
  input  logic              i_id_uses_rs,
  input  logic              i_id_uses_rt,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_ex_valid,
  input  logic              i_ex_regwrite,
  input  logic              i_ex_memread,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic [REG_AW-1:0] i_ex_rs,
  input  logic [REG_AW-1:0] i_ex_rt,
  input  logic              i_exm_regwrite,
  input  logic [REG_AW-1:0] i_exm_rd,
  input  logic              i_mwb_regwrite,
  input  logic [REG_AW-1:0] i_mwb_rd,
  output logic              o_hazard,
  output fwd_sel_e          o_fwd_a,
  output fwd_sel_e          o_fwd_b
);

  logic w_ex_hit;
  logic w_load_use;

  assign w_ex_hit = (i_ex_rd != '0) &
    ((i_id_uses_rs & (i_id_rs == i_ex_rd)) |
     (i_id_uses_rt & (i_id_rt == i_ex_rd)));

  assign w_load_use = i_id_valid & i_ex_valid &
    i_ex_memread & w_ex_hit;

`ifdef ID_EX_FWD_EN

  logic w_unused;
  assign w_unused = i_ex_regwrite;

  assign o_hazard = w_load_use;

  // EX/MEM beats MEM/WB; r0 never forwards
  always_comb begin
    o_fwd_a = FWD_REG;
    if (i_ex_rs != '0 && i_exm_regwrite &&
        i_exm_rd == i_ex_rs)
      o_fwd_a = FWD_EXM;
    else if (i_ex_rs != '0 && i_mwb_regwrite &&
             i_mwb_rd == i_ex_rs)
      o_fwd_a = FWD_MWB;
  end

  // same selection for the rt operand
  always_comb begin
    o_fwd_b = FWD_REG;
    if (i_ex_rt != '0 && i_exm_regwrite &&
        i_exm_rd == i_ex_rt)
      o_fwd_b = FWD_EXM;
    else if (i_ex_rt != '0 && i_mwb_regwrite &&
             i_mwb_rd == i_ex_rt)
      o_fwd_b = FWD_MWB;
  end

`else

  logic w_exm_hit;
  logic w_unused;

  assign w_unused = ^{i_ex_rs, i_ex_rt,
                      i_mwb_regwrite, i_mwb_rd};

  assign w_exm_hit = (i_exm_rd != '0) &
    ((i_id_uses_rs & (i_id_rs == i_exm_rd)) |
     (i_id_uses_rt & (i_id_rt == i_exm_rd)));

  // without bypass, wait for EX and EX/MEM writers
  assign o_hazard = w_load_use | (i_id_valid &
    ((i_ex_valid & i_ex_regwrite & w_ex_hit) |
     (i_exm_regwrite & w_exm_hit)));

  assign o_fwd_a = FWD_REG;
  assign o_fwd_b = FWD_REG;

`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register, operand select, stall counter.
// Build option: ID_EX_FWD_EN enables operand forwarding.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = MIPS_DATA_W,
  parameter int REG_AW = MIPS_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [2:0]        id_alu_sel,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              flush,
  input  logic              exm_regwrite,
  input  logic              mwb_regwrite,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic [DATA_W-1:0] mwb_result,
  output logic [DATA_W-1:0] ex_data1,
  output logic [DATA_W-1:0] ex_data2,
  output logic [2:0]        ex_sel,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic [REG_AW-1:0] ex_rd,
  output logic              stall_id,
  output logic [31:0]       stall_count
);

  logic              r_valid;
  logic              r_regwrite;
  logic              r_memread;
  logic              r_memwrite;
  logic              r_alusrc;
  logic [2:0]        r_sel;
  logic [REG_AW-1:0] r_rd;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [31:0]       r_stall_cnt;

  logic              w_hazard;
  logic              w_load;
  fwd_sel_e          w_fwd_a;
  fwd_sel_e          w_fwd_b;
  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;

  hazard_fwd_unit #(
    .REG_AW (REG_AW)
  ) u_hfu (
    .i_id_valid     (id_valid),
    .i_id_uses_rs   (id_uses_rs),
    .i_id_uses_rt   (id_uses_rt),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_ex_valid     (r_valid),
    .i_ex_regwrite  (r_regwrite),
    .i_ex_memread   (r_memread),
    .i_ex_rd        (r_rd),
    .i_ex_rs        (r_rs),
    .i_ex_rt        (r_rt),
    .i_exm_regwrite (exm_regwrite),
    .i_exm_rd       (exm_rd),
    .i_mwb_regwrite (mwb_regwrite),
    .i_mwb_rd       (mwb_rd),
    .o_hazard       (w_hazard),
    .o_fwd_a        (w_fwd_a),
    .o_fwd_b        (w_fwd_b)
  );

  // flush wins over hazard; reset masks any stall
  assign stall_id = rst_n & w_hazard & ~flush;
  assign w_load   = id_valid & ~flush & ~w_hazard;

  // capture ID instruction or insert a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_alusrc   <= 1'b0;
      r_sel      <= '0;
      r_rd       <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
    end else if (w_load) begin
      r_valid    <= 1'b1;
      r_regwrite <= id_regwrite;
      r_memread  <= id_memread;
      r_memwrite <= id_memwrite;
      r_alusrc   <= id_alusrc;
      r_sel      <= id_alu_sel;
      r_rd       <= id_rd;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_rs_data  <= id_rs_data;
      r_rt_data  <= id_rt_data;
      r_imm      <= id_imm;
    end else begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_alusrc   <= 1'b0;
      r_sel      <= '0;
      r_rd       <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
    end
  end

  // saturating count of hazard stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (stall_id && r_stall_cnt != 32'hFFFF_FFFF)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

`ifdef ID_EX_FWD_EN

  // rs operand bypass mux
  always_comb begin
    w_opa = r_rs_data;
    case (w_fwd_a)
      FWD_EXM: w_opa = exm_result;
      FWD_MWB: w_opa = mwb_result;
      default: w_opa = r_rs_data;
    endcase
  end

  // rt operand bypass mux
  always_comb begin
    w_opb = r_rt_data;
    case (w_fwd_b)
      FWD_EXM: w_opb = exm_result;
      FWD_MWB: w_opb = mwb_result;
      default: w_opb = r_rt_data;
    endcase
  end

`else

  logic w_unused;
  assign w_unused = ^{exm_result, mwb_result,
                      w_fwd_a, w_fwd_b};

  assign w_opa = r_rs_data;
  assign w_opb = r_rt_data;

`endif

  assign ex_data1      = w_opa;
  assign ex_data2      = r_alusrc ? r_imm : w_opb;
  assign ex_store_data = w_opb;
  assign ex_sel        = r_sel;
  assign ex_valid      = r_valid;
  assign ex_regwrite   = r_regwrite;
  assign ex_memread    = r_memread;
  assign ex_memwrite   = r_memwrite;
  assign ex_rd         = r_rd;
  assign stall_count   = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage.
// Works with and without ID_EX_FWD_EN.
module tb_id_ex_stage;

  typedef struct packed {
    bit        v;
    bit        rw;
    bit        mr;
    bit        mw;
    bit        asrc;
    bit [2:0]  sel;
    bit [4:0]  rd;
    bit [4:0]  rs;
    bit [4:0]  rt;
    bit [31:0] rsd;
    bit [31:0] rtd;
    bit [31:0] imm;
  } instr_t;

  typedef struct packed {
    instr_t    id;
    bit        urs;
    bit        urt;
    bit        flush;
    bit        exm_rw;
    bit [4:0]  exm_rd;
    bit [31:0] exm_res;
    bit        mwb_rw;
    bit [4:0]  mwb_rd;
    bit [31:0] mwb_res;
  } in_t;

  typedef struct packed {
    bit        stall;
    bit        v;
    bit        rw;
    bit        mr;
    bit        mw;
    bit [4:0]  rd;
    bit [2:0]  sel;
    bit [31:0] d1;
    bit [31:0] d2;
    bit [31:0] sd;
    bit [31:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        id_valid, id_uses_rs, id_uses_rt;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [2:0]  id_alu_sel;
  logic        id_alusrc, id_regwrite;
  logic        id_memread, id_memwrite;
  logic        flush;
  logic        exm_regwrite, mwb_regwrite;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic [31:0] ex_data1, ex_data2, ex_store_data;
  logic [2:0]  ex_sel;
  logic        ex_valid, ex_regwrite;
  logic        ex_memread, ex_memwrite;
  logic [4:0]  ex_rd;
  logic        stall_id;
  logic [31:0] stall_count;

  int     n_checks = 0;
  int     n_fail   = 0;
  exp_t   sb[$];
  instr_t m_ex;
  bit [31:0] m_cnt;

  id_ex_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .id_imm        (id_imm),
    .id_alu_sel    (id_alu_sel),
    .id_alusrc     (id_alusrc),
    .id_regwrite   (id_regwrite),
    .id_memread    (id_memread),
    .id_memwrite   (id_memwrite),
    .flush         (flush),
    .exm_regwrite  (exm_regwrite),
    .mwb_regwrite  (mwb_regwrite),
    .exm_rd        (exm_rd),
    .mwb_rd        (mwb_rd),
    .exm_result    (exm_result),
    .mwb_result    (mwb_result),
    .ex_data1      (ex_data1),
    .ex_data2      (ex_data2),
    .ex_sel        (ex_sel),
    .ex_store_data (ex_store_data),
    .ex_valid      (ex_valid),
    .ex_regwrite   (ex_regwrite),
    .ex_memread    (ex_memread),
    .ex_memwrite   (ex_memwrite),
    .ex_rd         (ex_rd),
    .stall_id      (stall_id),
    .stall_count   (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // ID source r (non-zero) read by the ID instr
  function automatic bit reads(in_t s, bit [4:0] r);
    return r != 0 &&
      ((s.urs && s.id.rs == r) ||
       (s.urt && s.id.rt == r));
  endfunction

  function automatic bit exp_stall(instr_t ex, in_t s);
    bit h;
    if (!s.id.v || s.flush) return 1'b0;
    h = ex.v && ex.mr && reads(s, ex.rd);
`ifndef ID_EX_FWD_EN
    h = h || (ex.v && ex.rw && reads(s, ex.rd));
    h = h || (s.exm_rw && reads(s, s.exm_rd));
`endif
    return h;
  endfunction

  function automatic bit [31:0] fwd(bit [4:0] r,
                                    bit [31:0] d,
                                    in_t s);
`ifdef ID_EX_FWD_EN
    if (r != 0 && s.exm_rw && s.exm_rd == r)
      return s.exm_res;
    if (r != 0 && s.mwb_rw && s.mwb_rd == r)
      return s.mwb_res;
`endif
    return d;
  endfunction

  task automatic advance(input in_t s, input bit st);
    if (s.id.v && !s.flush && !st) m_ex = s.id;
    else m_ex = '0;
    if (st && m_cnt != 32'hFFFF_FFFF) m_cnt++;
  endtask

  task automatic apply(input in_t s);
    id_valid     = s.id.v;
    id_regwrite  = s.id.rw;
    id_memread   = s.id.mr;
    id_memwrite  = s.id.mw;
    id_alusrc    = s.id.asrc;
    id_alu_sel   = s.id.sel;
    id_rd        = s.id.rd;
    id_rs        = s.id.rs;
    id_rt        = s.id.rt;
    id_rs_data   = s.id.rsd;
    id_rt_data   = s.id.rtd;
    id_imm       = s.id.imm;
    id_uses_rs   = s.urs;
    id_uses_rt   = s.urt;
    flush        = s.flush;
    exm_regwrite = s.exm_rw;
    exm_rd       = s.exm_rd;
    exm_result   = s.exm_res;
    mwb_regwrite = s.mwb_rw;
    mwb_rd       = s.mwb_rd;
    mwb_result   = s.mwb_res;
  endtask

  task automatic drive(input in_t s, output bit st);
    exp_t e;
    @(negedge clk);
    apply(s);
    st      = exp_stall(m_ex, s);
    e.stall = st;
    e.v     = m_ex.v;
    e.rw    = m_ex.rw;
    e.mr    = m_ex.mr;
    e.mw    = m_ex.mw;
    e.rd    = m_ex.rd;
    e.sel   = m_ex.sel;
    e.d1    = fwd(m_ex.rs, m_ex.rsd, s);
    e.sd    = fwd(m_ex.rt, m_ex.rtd, s);
    e.d2    = m_ex.asrc ? m_ex.imm : e.sd;
    e.cnt   = m_cnt;
    sb.push_back(e);
    advance(s, st);
  endtask

  function automatic in_t rnd_in();
    in_t s;
    s = '0;
    s.id.v    = $urandom_range(0, 3) != 0;
    s.id.rw   = 1'($urandom);
    s.id.mr   = 1'($urandom);
    s.id.mw   = 1'($urandom);
    s.id.asrc = 1'($urandom);
    s.id.sel  = 3'($urandom);
    s.id.rd   = 5'($urandom_range(0, 7));
    s.id.rs   = 5'($urandom_range(0, 7));
    s.id.rt   = 5'($urandom_range(0, 7));
    s.id.rsd  = $urandom;
    s.id.rtd  = $urandom;
    s.id.imm  = $urandom;
    s.urs     = 1'($urandom);
    s.urt     = 1'($urandom);
    s.flush   = $urandom_range(0, 7) == 0;
    s.exm_rw  = 1'($urandom);
    s.exm_rd  = 5'($urandom_range(0, 7));
    s.exm_res = $urandom;
    s.mwb_rw  = 1'($urandom);
    s.mwb_rd  = 5'($urandom_range(0, 7));
    s.mwb_res = $urandom;
    return s;
  endfunction

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall_id", 32'(stall_id), 32'(e.stall));
        chk("ex_valid", 32'(ex_valid), 32'(e.v));
        chk("ex_regwrite", 32'(ex_regwrite), 32'(e.rw));
        chk("ex_memread", 32'(ex_memread), 32'(e.mr));
        chk("ex_memwrite", 32'(ex_memwrite), 32'(e.mw));
        chk("ex_rd", 32'(ex_rd), 32'(e.rd));
        chk("ex_sel", 32'(ex_sel), 32'(e.sel));
        chk("ex_data1", ex_data1, e.d1);
        chk("ex_data2", ex_data2, e.d2);
        chk("ex_store_data", ex_store_data, e.sd);
        chk("stall_count", stall_count, e.cnt);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, 32'(ex_valid), 0);
    chk({tag, "_regwrite"}, 32'(ex_regwrite), 0);
    chk({tag, "_memread"}, 32'(ex_memread), 0);
    chk({tag, "_memwrite"}, 32'(ex_memwrite), 0);
    chk({tag, "_rd"}, 32'(ex_rd), 0);
    chk({tag, "_data1"}, ex_data1, 0);
    chk({tag, "_stall_id"}, 32'(stall_id), 0);
    chk({tag, "_count"}, stall_count, 0);
  endtask

  initial begin
    in_t s, lw, use_i, idle;
    bit  st;
    idle  = '0;
    m_ex  = '0;
    m_cnt = '0;
    rst_n = 1'b0;
    apply(idle);
    repeat (2) @(negedge clk);
    #1;
    chk_bubble("reset");
    rst_n = 1'b1;

    // add r3 = r1 + r2
    s = '0;
    s.id.v = 1; s.id.rw = 1; s.id.sel = 3'b000;
    s.id.rd = 3; s.id.rs = 1; s.id.rt = 2;
    s.id.rsd = 5; s.id.rtd = 7;
    s.urs = 1; s.urt = 1;
    drive(s, st);
    // EX holds rs=1: EX/MEM and MEM/WB both match
    s = idle;
    s.exm_rw = 1; s.exm_rd = 1; s.exm_res = 100;
    s.mwb_rw = 1; s.mwb_rd = 1; s.mwb_res = 200;
    drive(s, st);

    // lw r4 then add using r4 -> one stall
    lw = '0;
    lw.id.v = 1; lw.id.rw = 1; lw.id.mr = 1;
    lw.id.asrc = 1; lw.id.rd = 4; lw.id.imm = 8;
    lw.urs = 1;
    drive(lw, st);
    use_i = '0;
    use_i.id.v = 1; use_i.id.rw = 1; use_i.id.rd = 6;
    use_i.id.rs = 4; use_i.id.rt = 2;
    use_i.id.rsd = 11; use_i.id.rtd = 22;
    use_i.urs = 1; use_i.urt = 1;
    drive(use_i, st);
    drive(use_i, st);

    // load-use with flush in the same cycle
    lw.id.rd = 5;
    drive(lw, st);
    use_i.id.rs = 5;
    use_i.flush = 1;
    drive(use_i, st);
    use_i.flush = 0;
    drive(idle, st);

    // r0 must not forward or stall
    s = '0;
    s.id.v = 1; s.id.rw = 1; s.id.rd = 7;
    s.urs = 1;
    drive(s, st);
    s = idle;
    s.exm_rw = 1; s.exm_rd = 0;
    s.exm_res = 32'hFFFF_FFFF;
    s.id.v = 1; s.urs = 1;
    drive(s, st);

    // reset asserted during a stall
    lw.id.rd = 6;
    drive(lw, st);
    use_i.id.rs = 6;
    drive(use_i, st);
    #2;
    rst_n = 1'b0;
    #1;
    chk_bubble("midrst");
    #1;
    rst_n = 1'b1;
    m_ex  = '0;
    m_cnt = '0;
    advance(use_i, exp_stall(m_ex, use_i));
    drive(idle, st);

    // randomized traffic; stalled ID is re-presented
    st = 0;
    s  = idle;
    for (int i = 0; i < 600; i++) begin
      in_t n;
      n = rnd_in();
      if (st) begin
        n.id  = s.id;
        n.urs = s.urs;
        n.urt = s.urt;
      end
      s = n;
      drive(s, st);
    end

    drive(idle, st);
    @(negedge clk);
    #3;
    chk("sb_drain", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width of operands and results.
REQ-002 Parameter REG_AW, default 5, register-address width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 id_valid, id_uses_rs, id_uses_rt  input  1 each  ID-stage instruction valid / reads rs / reads rt.
REQ-006 id_rs, id_rt, id_rd  input  REG_AW each  ID source and destination register numbers.
REQ-007 id_rs_data, id_rt_data, id_imm  input  DATA_W each  register-file read data and sign-extended immediate.
REQ-008 id_alu_sel  input  3  ALU operation code (000 add ... 111 shift-right-1).
REQ-009 id_alusrc, id_regwrite, id_memread, id_memwrite  input  1 each  ID control bits.
REQ-010 flush  input  1  squash the ID instruction (taken branch/jump).
REQ-011 exm_regwrite, mwb_regwrite  input  1 each  EX/MEM and MEM/WB write enables.
REQ-012 exm_rd, mwb_rd  input  REG_AW each; exm_result, mwb_result  input  DATA_W each  downstream destinations and values.
REQ-013 ex_data1, ex_data2  output  DATA_W each  ALU operands; ex_sel  output  3  ALU operation.
REQ-014 ex_store_data  output  DATA_W  forwarded rt value for stores.
REQ-015 ex_valid, ex_regwrite, ex_memread, ex_memwrite  output  1 each; ex_rd  output  REG_AW.
REQ-016 stall_id  output  1  hold PC and IF/ID this cycle; stall_count  output  32  hazard-stall cycles.

Function
REQ-017 Each rising edge without reset SHALL load the ID fields into the stage register: instruction when load enabled, bubble otherwise; one-cycle latency ID->EX.
REQ-018 Bubble SHALL set ex_valid, ex_regwrite, ex_memread, ex_memwrite to 0 and all data/address fields to 0.
REQ-019 Load-use hazard SHALL be: ex_valid & ex_memread & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)) & id_valid.
REQ-020 stall_id SHALL be combinational = hazard & ~flush; during a stall cycle a bubble SHALL be loaded and the ID instruction re-presented next cycle.
REQ-021 flush SHALL load a bubble and force stall_id=0, taking priority over hazard in the same cycle.
REQ-022 Operand forwarding (FWD_EN) SHALL select per source: EX/MEM if exm_regwrite & exm_rd==src & src!=0; else MEM/WB if mwb_regwrite & mwb_rd==src & src!=0; else registered data; EX/MEM wins when both match.
REQ-023 ex_data1 SHALL be forwarded rs; ex_data2 SHALL be registered imm when registered alusrc=1, else forwarded rt; ex_store_data SHALL be forwarded rt.
REQ-024 Register 0 SHALL never be a hazard or forwarding source.
REQ-025 stall_count SHALL increment by 1 on each edge where stall_id=1, saturating at 32'hFFFF_FFFF.

Reset
REQ-026 rst_n low SHALL immediately force all stage registers to bubble and stall_count to 0; stall_id SHALL read 0 while reset asserted.
REQ-027 Reset mid-stall SHALL drop the pending stall; first post-reset edge loads ID normally.

Configuration
REQ-028 Macro ID_EX_FWD_EN defined: forwarding per REQ-022, stalls only for load-use.
REQ-029 Macro ID_EX_FWD_EN undefined: no forwarding muxes, operands are registered data; hazard SHALL additionally include any source matching a valid regwrite destination in EX (ex_rd) or EX/MEM (exm_rd), rd!=0; MEM/WB relies on write-before-read register file.

Structure
REQ-030 Package mips_pkg SHALL hold ALU-op encodings (3-bit), REG_AW/DATA_W constants, and forward-select enum (FWD_REG, FWD_EXM, FWD_MWB).
REQ-031 Hazard and forward-select logic SHALL be sub-module hazard_fwd_unit (combinational); pipeline register and counter stay in id_ex_stage.

Verification
REQ-032 Reset then ID add r3=r1+r2 (rs_data 5, rt_data 7, sel 000) -> next cycle ex_data1=5, ex_data2=7, ex_rd=3, ex_regwrite=1, ex_valid=1.
REQ-033 exm_regwrite=1, exm_rd=1, exm_result=100 and mwb_rd=1, mwb_result=200 while EX holds rs=1 -> ex_data1=100 (FWD_EN); undefined -> registered value.
REQ-034 EX lw r4, ID add uses rs=4 -> stall_id=1 one cycle, bubble in EX, stall_count=1, add enters EX next edge.
REQ-035 Load-use hazard and flush same cycle -> stall_id=0, bubble loaded, stall_count unchanged.
REQ-036 exm_regwrite=1, exm_rd=0, exm_result=FFFF_FFFF with rs=0 -> ex_data1 = registered 0, no stall.
REQ-037 rst_n pulsed low mid-stall -> outputs bubble immediately, stall_count=0, stall_id=0.
